// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its event FIFO.
// Board defaults assume a 50 MHz clock.
package keypad_pkg;

    localparam int unsigned BOARD_ROW_TICKS   = 250000;
    localparam int unsigned BOARD_SAMPLE_TICK = 125000;

    // Wide enough for the largest supported 8x8 matrix.
    localparam int unsigned EVT_CODE_W = 6;

    typedef enum logic [1:0] {
        DWELL,
        SAMPLE,
        EMIT
    } scan_state_e;

    typedef struct packed {
        logic [EVT_CODE_W-1:0] code;
        logic                  press;
    } key_evt_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic key_evt_t make_evt(input int unsigned code, input logic press);
        key_evt_t e;
        e.code  = EVT_CODE_W'(code);
        e.press = press;
        return e;
    endfunction

    function automatic int unsigned evt_code_of(input key_evt_t e);
        return 32'(e.code);
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-strobed keypad scanner: per-key debounce counters feed a press/release
// event FIFO, alongside a live debounced key bitmap.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS        = 4,
    parameter  int COLS        = 4,
    parameter  int ROW_TICKS   = int'(BOARD_ROW_TICKS),
    parameter  int SAMPLE_TICK = int'(BOARD_SAMPLE_TICK),
    parameter  int DEBOUNCE_N  = 3,
    parameter  int FIFO_DEPTH  = 4,
    localparam int KW          = clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      col_in,
    output logic [ROWS-1:0]      row_out,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KW-1:0]        evt_code,
    output logic                 evt_press,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int NKEYS = ROWS*COLS;
    localparam int RW    = clog2(ROWS);
    localparam int CW    = clog2(COLS);
    localparam int TW    = clog2(ROW_TICKS);
    localparam int CNTW  = 4;

    logic [COLS-1:0] col_meta;
    logic [COLS-1:0] col_sync;
    logic [COLS-1:0] samp;

    logic            scan_en;
    logic [TW-1:0]   tick;
    logic            tick_wrap;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_nxt;

    scan_state_e     state;
    scan_state_e     state_nxt;
    logic            samp_load;
    logic            emit_en;
    logic [CW-1:0]   col_idx;

    logic [CNTW-1:0] cnt [NKEYS];
    logic [KW-1:0]   key_idx;
    logic            key_pressed;
    logic            key_differs;
    logic [CNTW-1:0] cnt_inc;
    logic            key_flip;

    key_evt_t        push_evt;
    key_evt_t        head_evt;
    logic            fifo_empty;
    logic            fifo_drop;

    assign tick_wrap = (tick == TW'(ROW_TICKS-1));
    assign row_nxt   = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;

    // The first post-reset edge only raises the row-0 strobe, so every row,
    // row 0 included, is held for a full ROW_TICKS.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_en <= 1'b0;
            tick    <= '0;
            row_idx <= '0;
            row_out <= '1;
        end else if (!scan_en) begin
            scan_en <= 1'b1;
            row_out <= ~(ROWS'(1) << row_idx);
        end else if (tick_wrap) begin
            tick    <= '0;
            row_idx <= row_nxt;
            row_out <= ~(ROWS'(1) << row_nxt);
        end else begin
            tick    <= tick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DWELL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DWELL:   if (scan_en && tick == TW'(SAMPLE_TICK)) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = EMIT;
            EMIT:    if (col_idx == CW'(COLS-1)) state_nxt = DWELL;
            default: state_nxt = DWELL;
        endcase
    end

    always_comb begin
        samp_load = (state == SAMPLE);
        emit_en   = (state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= '1;
            col_sync <= '1;
            samp     <= '1;
            col_idx  <= '0;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
            if (samp_load) begin
                samp    <= col_sync;
                col_idx <= '0;
            end else if (emit_en) begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

    always_comb begin
        key_idx     = KW'(int'(row_idx) * COLS + int'(col_idx));
        key_pressed = ~samp[col_idx];
        key_differs = (key_pressed != key_state[key_idx]);
        cnt_inc     = cnt[key_idx] + 1'b1;
        key_flip    = emit_en & key_differs & (cnt_inc == CNTW'(DEBOUNCE_N));
        push_evt    = make_evt(32'(key_idx), key_pressed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else if (emit_en) begin
            if (!key_differs) begin
                cnt[key_idx] <= '0;
            end else if (key_flip) begin
                cnt[key_idx]       <= '0;
                key_state[key_idx] <= key_pressed;
            end else begin
                cnt[key_idx] <= cnt_inc;
            end
        end
    end

    keypad_evt_fifo #(
        .WIDTH ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (key_flip),
        .din   (push_evt),
        .pop   (evt_ready),
        .dout  (head_evt),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = KW'(evt_code_of(head_evt));
    assign evt_press = head_evt.press;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)            overflow <= 1'b0;
        else if (fifo_drop) overflow <= 1'b1;
        else if (ovf_clr)   overflow <= 1'b0;
    end

endmodule
